// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin arbiter moving words from four FWFT input FIFOs
// to four output FIFOs, with per-destination back-pressure skipping.
//
// Ports:
//   clk             - single clock, all state updates on posedge
//   reset           - synchronous active-low reset
//   active          - system FSM active; enables arbitration (IDLE/RUN)
//   empty_in[3:0]   - input FIFO empty flags
//   data_in         - input FIFO heads, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   almost_full_out - output FIFO almost-full flags (umbral_H threshold)
//   pop[3:0]        - combinational one-hot-or-zero read strobe
//   push[3:0]       - registered one-hot-or-zero write strobe (dest of word)
//   data_out        - registered word written with push, held otherwise
//   idle_arb        - registered "no work in flight" flag
//   cnt_push[7:0]   - wrapping push counter
//
// Build option: define ARB_CNT_PUSH_EN to implement the push counter;
// without it cnt_push is tied to 0 and no counter register exists.

module arbitro_rr #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic [3:0]              empty_in,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    input  logic [3:0]              almost_full_out,
    output logic [3:0]              pop,
    output logic [3:0]              push,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    idle_arb,
    output logic [7:0]              cnt_push
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [3:0]              push_q, push_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    idle_q, idle_d;

    logic [1:0]              dest_w [4];
    logic [3:0]              elig;
    logic                    run_en;
    logic                    gnt_vld;
    logic [1:0]              gnt_idx;
    logic [DATA_WIDTH-1:0]   gnt_word;

    // Grants are gated by the registered state (not by active) so a grant
    // already decided in the cycle active falls still completes.
    assign run_en = (state_q == S_RUN) && reset;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dest_w[i] = data_in[i*DATA_WIDTH + DATA_WIDTH - 2 +: 2];
            elig[i]   = run_en && !empty_in[i]
                        && !almost_full_out[dest_w[i]];
        end
    end

    // First eligible input from ptr onward; ineligible heads are skipped.
    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_word = data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        pop = 4'b0000;
        if (gnt_vld) begin
            pop = 4'b0001 << gnt_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (active)  state_d = S_RUN;
            S_RUN:   if (!active) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        push_d = 4'b0000;
        data_d = data_q;
        if (gnt_vld) begin
            ptr_d  = gnt_idx + 2'd1;
            push_d = 4'b0001 << dest_w[gnt_idx];
            data_d = gnt_word;
        end
    end

    always_comb begin
        idle_d = (state_d == S_IDLE)
                 || ((state_q == S_RUN) && (&empty_in) && !gnt_vld);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            push_q  <= 4'b0000;
            data_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            push_q  <= push_d;
            data_q  <= data_d;
            idle_q  <= idle_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign idle_arb = idle_q;

`ifdef ARB_CNT_PUSH_EN
    logic [7:0] cnt_q, cnt_d;

    // Counts each edge at which the registered push strobe is active.
    always_comb begin
        cnt_d = cnt_q;
        if (|push_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_push = cnt_q;
`else
    assign cnt_push = 8'd0;
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: table of per-cycle vectors plus
// hand sequences for reset and the optional push counter.

module tb_arbitro_rr;

    localparam int DW = 6;

    logic            clk;
    logic            reset;
    logic            active;
    logic [3:0]      empty_in;
    logic [4*DW-1:0] data_in;
    logic [3:0]      almost_full_out;
    logic [3:0]      pop;
    logic [3:0]      push;
    logic [DW-1:0]   data_out;
    logic            idle_arb;
    logic [7:0]      cnt_push;

    int total;
    int bad;

    arbitro_rr #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .active          (active),
        .empty_in        (empty_in),
        .data_in         (data_in),
        .almost_full_out (almost_full_out),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .idle_arb        (idle_arb),
        .cnt_push        (cnt_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            rst;
        logic            act;
        logic [3:0]      emp;
        logic [4*DW-1:0] din;
        logic [3:0]      af;
        logic [3:0]      e_pop;
        logic [3:0]      e_push;
        logic [DW-1:0]   e_dout;
        logic            e_idle;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t",
                     nm, act_v, exp_v, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset           = v.rst;
        active          = v.act;
        empty_in        = v.emp;
        data_in         = v.din;
        almost_full_out = v.af;
        #2;
        chk({v.name, ".pop"}, 32'(pop), 32'(v.e_pop));
        @(posedge clk);
        #1;
        chk({v.name, ".push"}, 32'(push), 32'(v.e_push));
        chk({v.name, ".dout"}, 32'(data_out), 32'(v.e_dout));
        chk({v.name, ".idle"}, 32'(idle_arb), 32'(v.e_idle));
`ifndef ARB_CNT_PUSH_EN
        chk({v.name, ".cnt"}, 32'(cnt_push), 32'd0);
`endif
    endtask

    function automatic vec_t mk(input string n, input logic r,
                                input logic a, input logic [3:0] e,
                                input logic [4*DW-1:0] d,
                                input logic [3:0] f, input logic [3:0] p,
                                input logic [3:0] pu,
                                input logic [DW-1:0] o, input logic i);
        vec_t v;
        v.name = n; v.rst = r; v.act = a; v.emp = e; v.din = d;
        v.af = f; v.e_pop = p; v.e_push = pu; v.e_dout = o; v.e_idle = i;
        return v;
    endfunction

    // Heads: DA has dest 0,1,2,3 on inputs 0..3; DB has dest 2 on 0 and 1.
    localparam logic [4*DW-1:0] DA = {6'h3D, 6'h2C, 6'h1B, 6'h0A};
    localparam logic [4*DW-1:0] DB = {6'h3D, 6'h2C, 6'h22, 6'h21};

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        active = 1'b1;
        empty_in = 4'b0000;
        data_in = DA;
        almost_full_out = 4'b0000;

        vecs[0]  = mk("idle_after_rst", 1, 0, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h00, 1);
        vecs[1]  = mk("go_run",         1, 1, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h00, 0);
        vecs[2]  = mk("rr0",            1, 1, 4'h0, DA, 4'h0, 4'h1, 4'h1, 6'h0A, 0);
        vecs[3]  = mk("rr1",            1, 1, 4'h0, DA, 4'h0, 4'h2, 4'h2, 6'h1B, 0);
        vecs[4]  = mk("rr2",            1, 1, 4'h0, DA, 4'h0, 4'h4, 4'h4, 6'h2C, 0);
        vecs[5]  = mk("rr3",            1, 1, 4'h0, DA, 4'h0, 4'h8, 4'h8, 6'h3D, 0);
        vecs[6]  = mk("bp_a",           1, 1, 4'hC, DB, 4'h4, 4'h0, 4'h0, 6'h3D, 0);
        vecs[7]  = mk("bp_b",           1, 1, 4'hC, DB, 4'h4, 4'h0, 4'h0, 6'h3D, 0);
        vecs[8]  = mk("bp_clr0",        1, 1, 4'hC, DB, 4'h0, 4'h1, 4'h4, 6'h21, 0);
        vecs[9]  = mk("bp_clr1",        1, 1, 4'hC, DB, 4'h0, 4'h2, 4'h4, 6'h22, 0);
        vecs[10] = mk("all_empty",      1, 1, 4'hF, DB, 4'h0, 4'h0, 4'h0, 6'h22, 1);
        vecs[11] = mk("skip2",          1, 1, 4'h0, DA, 4'h4, 4'h8, 4'h8, 6'h3D, 0);
        vecs[12] = mk("skip0",          1, 1, 4'h0, DA, 4'h1, 4'h2, 4'h2, 6'h1B, 0);
        vecs[13] = mk("act_drop",       1, 0, 4'h0, DA, 4'h0, 4'h4, 4'h4, 6'h2C, 1);
        vecs[14] = mk("after_drop",     1, 0, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h2C, 1);
        vecs[15] = mk("rerun",          1, 1, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h2C, 0);
        vecs[16] = mk("grant_ptr3",     1, 1, 4'h0, DA, 4'h0, 4'h8, 4'h8, 6'h3D, 0);
        vecs[17] = mk("rst_mid",        0, 1, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h00, 1);
        vecs[18] = mk("rst_rel",        1, 1, 4'h0, DA, 4'h0, 4'h0, 4'h0, 6'h00, 0);
        vecs[19] = mk("first_after",    1, 1, 4'h0, DA, 4'h0, 4'h1, 4'h1, 6'h0A, 0);

        // Two reset cycles with heads present: no pop allowed.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            chk("rst_pop", 32'(pop), 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i]);
        end

`ifdef ARB_CNT_PUSH_EN
        // 257 pushes wrap the 8-bit counter to 1.
        @(negedge clk);
        reset = 1'b0;
        active = 1'b1;
        empty_in = 4'b0000;
        data_in = DA;
        almost_full_out = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("cnt_rst", 32'(cnt_push), 32'd0);
        @(negedge clk);
        for (int n = 0; n < 257; n++) begin
            if (n == 256) active = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("cnt_wrap", 32'(cnt_push), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
